// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle for the multi-cycle RV32I core.
// master = control unit, slave = datapath side.
interface multicycle_control_unit_if #(
  parameter int INSTR_WIDTH = 32
);
  logic [INSTR_WIDTH-1:0] instr_i;
  logic                   eq_i;
  logic                   mem_ready_i;
  logic                   PCWrite_o;
  logic                   AdrSrc_o;
  logic                   MemWrite_o;
  logic                   IRWrite_o;
  logic [1:0]             ResultSrc_o;
  logic [1:0]             ALUSrcA_o;
  logic [1:0]             ALUSrcB_o;
  logic [2:0]             ALUControl_o;
  logic [1:0]             ImmSrc_o;
  logic                   RegWrite_o;
  logic                   illegal_o;
  logic [3:0]             state_o;

  modport master (
    input  instr_i, eq_i, mem_ready_i,
    output PCWrite_o, AdrSrc_o, MemWrite_o,
    output IRWrite_o, ResultSrc_o,
    output ALUSrcA_o, ALUSrcB_o, ALUControl_o,
    output ImmSrc_o, RegWrite_o, illegal_o,
    output state_o
  );

  modport slave (
    output instr_i, eq_i, mem_ready_i,
    input  PCWrite_o, AdrSrc_o, MemWrite_o,
    input  IRWrite_o, ResultSrc_o,
    input  ALUSrcA_o, ALUSrcB_o, ALUControl_o,
    input  ImmSrc_o, RegWrite_o, illegal_o,
    input  state_o
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences one shared ALU
// and a unified memory with a ready handshake.
module multicycle_control_unit #(
  parameter int INSTR_WIDTH = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10
  } state_t;

  state_t state;
  state_t nxt;
  state_t cur;

  logic [INSTR_WIDTH-1:0] instr;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;
  logic       ready;
  logic       is_load;
  logic       is_store;
  logic       is_r;
  logic       is_i;
  logic       is_jal;
  logic       is_bop;
  logic       is_br;
  logic [1:0] alu_op;
  logic [2:0] alu_ctl;
  logic       pcw;
  logic       irw;
  logic       memw;
  logic       regw;
  logic       ill;
  logic       unused_bits;

  assign instr = bus.instr_i;
  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7b5  = instr[30];
  assign unused_bits = ^{instr[INSTR_WIDTH-1:31],
                         instr[29:15], instr[11:7]};

  assign ready = MEM_WAIT_EN ? bus.mem_ready_i : 1'b1;

  assign is_load  = (opc == 7'b0000011);
  assign is_store = (opc == 7'b0100011);
  assign is_r     = (opc == 7'b0110011);
  assign is_i     = (opc == 7'b0010011);
  assign is_jal   = (opc == 7'b1101111);
  assign is_bop   = (opc == 7'b1100011);
  assign is_br    = is_bop & (f3[2:1] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= nxt;
  end

  // Reset forces FETCH-valued outputs even mid-instruction.
  assign cur = rst ? FETCH : state;

  always_comb begin
    nxt             = cur;
    pcw             = 1'b0;
    irw             = 1'b0;
    memw            = 1'b0;
    regw            = 1'b0;
    ill             = 1'b0;
    alu_op          = 2'b00;
    bus.AdrSrc_o    = 1'b0;
    bus.ResultSrc_o = 2'b00;
    bus.ALUSrcA_o   = 2'b00;
    bus.ALUSrcB_o   = 2'b00;
    unique case (cur)
      FETCH: begin
        bus.ALUSrcB_o   = 2'b10;
        bus.ResultSrc_o = 2'b10;
        irw             = ready;
        pcw             = ready;
        if (ready) nxt = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA_o = 2'b01;
        bus.ALUSrcB_o = 2'b01;
        unique case (1'b1)
          is_load, is_store: nxt = MEMADR;
          is_r:              nxt = EXECR;
          is_i:              nxt = EXECI;
          is_jal:            nxt = JAL;
          is_br:             nxt = BRANCH;
          default: begin
            nxt = FETCH;
            ill = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA_o = 2'b10;
        bus.ALUSrcB_o = 2'b01;
        nxt = opc[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.AdrSrc_o = 1'b1;
        if (ready) nxt = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc_o = 2'b01;
        regw            = 1'b1;
        nxt             = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc_o = 1'b1;
        memw         = 1'b1;
        if (ready) nxt = FETCH;
      end
      EXECR: begin
        bus.ALUSrcA_o = 2'b10;
        alu_op        = 2'b10;
        nxt           = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA_o = 2'b10;
        bus.ALUSrcB_o = 2'b01;
        alu_op        = 2'b10;
        nxt           = ALUWB;
      end
      JAL: begin
        bus.ALUSrcA_o = 2'b01;
        bus.ALUSrcB_o = 2'b10;
        pcw           = 1'b1;
        nxt           = ALUWB;
      end
      ALUWB: begin
        regw = 1'b1;
        nxt  = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcA_o = 2'b10;
        alu_op        = 2'b01;
        pcw           = bus.eq_i ^ f3[0];
        nxt           = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    alu_ctl = 3'b000;
    unique case (alu_op)
      2'b01: alu_ctl = 3'b001;
      2'b10: begin
        unique case (f3)
          3'b000:  alu_ctl = (opc[5] & f7b5) ? 3'b001
                                             : 3'b000;
          3'b010:  alu_ctl = 3'b101;
          3'b110:  alu_ctl = 3'b011;
          3'b111:  alu_ctl = 3'b010;
          default: alu_ctl = 3'b000;
        endcase
      end
      default: alu_ctl = 3'b000;
    endcase
  end

  always_comb begin
    bus.ImmSrc_o = 2'b00;
    unique case (1'b1)
      is_store: bus.ImmSrc_o = 2'b01;
      is_bop:   bus.ImmSrc_o = 2'b10;
      is_jal:   bus.ImmSrc_o = 2'b11;
      default:  bus.ImmSrc_o = 2'b00;
    endcase
  end

  assign bus.ALUControl_o = alu_ctl;
  assign bus.PCWrite_o    = pcw  & ~rst;
  assign bus.IRWrite_o    = irw  & ~rst;
  assign bus.MemWrite_o   = memw & ~rst;
  assign bus.RegWrite_o   = regw & ~rst;
  assign bus.illegal_o    = ill  & ~rst;
  assign bus.state_o      = cur;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multi-cycle control FSM with a
// per-cycle expected-output scoreboard.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  multicycle_control_unit_if bus ();

  multicycle_control_unit #(
    .INSTR_WIDTH(32),
    .MEM_WAIT_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [20:0] v;
    logic [20:0] care;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [20:0] obs;
  assign obs = {bus.state_o, bus.PCWrite_o,
                bus.IRWrite_o, bus.MemWrite_o,
                bus.RegWrite_o, bus.illegal_o,
                bus.AdrSrc_o, bus.ResultSrc_o,
                bus.ALUSrcA_o, bus.ALUSrcB_o,
                bus.ALUControl_o, bus.ImmSrc_o};

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      assert ((obs & e.care) === (e.v & e.care))
      else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h care=%h",
               e.tag, obs, e.v, e.care);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // f: ready in FETCH, illegal in DECODE, taken in BRANCH
  task automatic s(input string tag,
                   input logic [3:0] st,
                   input logic [1:0] imm,
                   input logic f,
                   input logic [2:0] alu);
    logic pw, iw, mw, rw, il, ad;
    logic [1:0] rs, sa, sb;
    logic [2:0] al;
    logic [20:0] care;
    exp_t e;
    pw = 0; iw = 0; mw = 0; rw = 0; il = 0; ad = 0;
    rs = 0; sa = 0; sb = 0; al = 0;
    care = '1;
    case (st)
      4'd0: begin
        pw = f; iw = f; rs = 2'b10; sb = 2'b10;
      end
      4'd1: begin
        il = f; sa = 2'b01; sb = 2'b01;
        care[11:9] = '0;
      end
      4'd2: begin
        sa = 2'b10; sb = 2'b01;
        care[11:9] = '0;
      end
      4'd3: begin
        ad = 1; care[8:2] = '0;
      end
      4'd4: begin
        rw = 1; rs = 2'b01;
        care[11] = 0; care[8:2] = '0;
      end
      4'd5: begin
        mw = 1; ad = 1; care[8:2] = '0;
      end
      4'd6: begin
        sa = 2'b10; al = alu;
        care[11:9] = '0;
      end
      4'd7: begin
        sa = 2'b10; sb = 2'b01; al = alu;
        care[11:9] = '0;
      end
      4'd8: begin
        rw = 1; care[11] = 0; care[8:2] = '0;
      end
      4'd9: begin
        pw = 1; sa = 2'b01; sb = 2'b10;
        care[11] = 0;
      end
      4'd10: begin
        pw = f; sa = 2'b10; al = 3'b001;
        care[11] = 0;
      end
      default: ;
    endcase
    e.tag  = tag;
    e.v    = {st, pw, iw, mw, rw, il, ad,
              rs, sa, sb, al, imm};
    e.care = care;
    sbq.push_back(e);
    cyc();
  endtask

  initial begin
    bus.instr_i     = 32'h002081B3;
    bus.eq_i        = 1'b0;
    bus.mem_ready_i = 1'b1;
    rst             = 1'b1;
    s("rst0", 0, 2'b00, 0, 0);
    s("rst1", 0, 2'b00, 0, 0);
    rst = 1'b0;

    s("add_f", 0, 2'b00, 1, 0);
    s("add_d", 1, 2'b00, 0, 0);
    s("add_ex", 6, 2'b00, 0, 3'b000);
    s("add_wb", 8, 2'b00, 0, 0);

    bus.instr_i = 32'h402081B3;
    s("sub_f", 0, 2'b00, 1, 0);
    s("sub_d", 1, 2'b00, 0, 0);
    s("sub_ex", 6, 2'b00, 0, 3'b001);
    s("sub_wb", 8, 2'b00, 0, 0);

    bus.instr_i = 32'h0020F1B3;
    s("and_f", 0, 2'b00, 1, 0);
    s("and_d", 1, 2'b00, 0, 0);
    s("and_ex", 6, 2'b00, 0, 3'b010);
    s("and_wb", 8, 2'b00, 0, 0);

    bus.instr_i = 32'hC0010093;
    s("addi_f", 0, 2'b00, 1, 0);
    s("addi_d", 1, 2'b00, 0, 0);
    s("addi_ex", 7, 2'b00, 0, 3'b000);
    s("addi_wb", 8, 2'b00, 0, 0);

    bus.instr_i = 32'h00A12093;
    s("slti_f", 0, 2'b00, 1, 0);
    s("slti_d", 1, 2'b00, 0, 0);
    s("slti_ex", 7, 2'b00, 0, 3'b101);
    s("slti_wb", 8, 2'b00, 0, 0);

    bus.instr_i     = 32'h0080A283;
    bus.mem_ready_i = 1'b0;
    s("lw_fwait", 0, 2'b00, 0, 0);
    bus.mem_ready_i = 1'b1;
    s("lw_f", 0, 2'b00, 1, 0);
    s("lw_d", 1, 2'b00, 0, 0);
    s("lw_adr", 2, 2'b00, 0, 0);
    bus.mem_ready_i = 1'b0;
    s("lw_rd0", 3, 2'b00, 0, 0);
    s("lw_rd1", 3, 2'b00, 0, 0);
    s("lw_rd2", 3, 2'b00, 0, 0);
    bus.mem_ready_i = 1'b1;
    s("lw_rd3", 3, 2'b00, 0, 0);
    s("lw_wb", 4, 2'b00, 0, 0);

    bus.instr_i = 32'h00512223;
    s("sw_f", 0, 2'b01, 1, 0);
    s("sw_d", 1, 2'b01, 0, 0);
    s("sw_adr", 2, 2'b01, 0, 0);
    bus.mem_ready_i = 1'b0;
    s("sw_wr0", 5, 2'b01, 0, 0);
    s("sw_wr1", 5, 2'b01, 0, 0);
    bus.mem_ready_i = 1'b1;
    s("sw_wr2", 5, 2'b01, 0, 0);

    bus.instr_i = 32'h00208463;
    bus.eq_i    = 1'b1;
    s("beq1_f", 0, 2'b10, 1, 0);
    s("beq1_d", 1, 2'b10, 0, 0);
    s("beq1_br", 10, 2'b10, 1, 0);
    bus.eq_i = 1'b0;
    s("beq0_f", 0, 2'b10, 1, 0);
    s("beq0_d", 1, 2'b10, 0, 0);
    s("beq0_br", 10, 2'b10, 0, 0);

    bus.instr_i = 32'h00209463;
    s("bne0_f", 0, 2'b10, 1, 0);
    s("bne0_d", 1, 2'b10, 0, 0);
    s("bne0_br", 10, 2'b10, 1, 0);
    bus.eq_i = 1'b1;
    s("bne1_f", 0, 2'b10, 1, 0);
    s("bne1_d", 1, 2'b10, 0, 0);
    s("bne1_br", 10, 2'b10, 0, 0);
    bus.eq_i = 1'b0;

    bus.instr_i = 32'h010000EF;
    s("jal_f", 0, 2'b11, 1, 0);
    s("jal_d", 1, 2'b11, 0, 0);
    s("jal_j", 9, 2'b11, 0, 0);
    s("jal_wb", 8, 2'b11, 0, 0);

    bus.instr_i = 32'h0000007F;
    s("ill_f", 0, 2'b00, 1, 0);
    s("ill_d", 1, 2'b00, 1, 0);

    bus.instr_i = 32'h0020C463;
    s("blt_f", 0, 2'b10, 1, 0);
    s("blt_d", 1, 2'b10, 1, 0);

    bus.instr_i = 32'h0080A283;
    s("lwr_f", 0, 2'b00, 1, 0);
    s("lwr_d", 1, 2'b00, 0, 0);
    s("lwr_adr", 2, 2'b00, 0, 0);
    bus.mem_ready_i = 1'b0;
    s("lwr_rd", 3, 2'b00, 0, 0);
    bus.mem_ready_i = 1'b1;
    rst = 1'b1;
    s("lwr_rst", 0, 2'b00, 0, 0);
    rst = 1'b0;
    s("post_f", 0, 2'b00, 1, 0);
    s("post_d", 1, 2'b00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
